// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles every bus of the memory arbiter: the instruction-fetch requester,
// the data requester, the shared single-port memory, and the stall/err
// status outputs.
//
// Handshake: a requester raises xReq together with its operands and holds
// them stable until it sees xAck high for exactly one cycle. The arbiter
// keeps memCe high for the whole grant, and the memory completes the
// access by raising memAck for one cycle with memRdData valid in that same
// cycle.
//
// Modports
//   slave  : the arbiter's side (requests and memory response in, acks,
//            read data, memory request, stall, err and dbg_state out)
//   master : the environment's side (exact mirror of slave)
//
// Signals
//   iReq/iAddr/iData/iAck                : instruction-fetch port (read-only)
//   dReq/dWr/dAddr/dWtData/dRdData/dAck  : data port
//   memCe/memWe/memAddr/memWtData        : shared memory request
//   memRdData/memAck                     : shared memory response
//   stall                                : pipeline hold request
//   err                                  : one-cycle abort flag
//   dbg_state                            : arbiter FSM state (debug)
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          iReq;
  logic [AW-1:0] iAddr;
  logic [DW-1:0] iData;
  logic          iAck;

  logic          dReq;
  logic          dWr;
  logic [AW-1:0] dAddr;
  logic [DW-1:0] dWtData;
  logic [DW-1:0] dRdData;
  logic          dAck;

  logic          memCe;
  logic          memWe;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memWtData;
  logic [DW-1:0] memRdData;
  logic          memAck;

  logic          stall;
  logic          err;
  logic [1:0]    dbg_state;

  modport slave (
    input  iReq, iAddr, dReq, dWr, dAddr, dWtData, memRdData, memAck,
    output iData, iAck, dRdData, dAck, memCe, memWe, memAddr, memWtData,
    output stall, err, dbg_state
  );

  modport master (
    output iReq, iAddr, dReq, dWr, dAddr, dWtData, memRdData, memAck,
    input  iData, iAck, dRdData, dAck, memCe, memWe, memAddr, memWtData,
    input  stall, err, dbg_state
  );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port memory between an instruction-fetch port and a data
// port. A three-state FSM (IDLE, IGRANT, DGRANT) grants one requester at a
// time. The data port wins ties, except that after three consecutive data
// wins against a waiting fetch the fetch is granted. Operands are latched on
// the grant edge, and the memory request is driven from the latched copies.
//
// Parameters
//   AW      : address width
//   DW      : data width
//   TIMEOUT : grant cycles without memAck before an abort (timeout build only)
//
// Ports
//   clk : single clock, rising edge
//   rst : synchronous, active-high reset
//   bus : mem_arbiter_if.slave (requesters, memory, stall, err, dbg_state)
//
// Build option
//   MEMARB_TIMEOUT_EN : when defined, a grant that waits TIMEOUT cycles
//   without memAck is aborted. The granted port gets an ack together with
//   err, and its read data is loaded with 0. When undefined, a grant waits
//   for memAck indefinitely and err is tied low.
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    streak_q, streak_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          wr_q, wr_d;
  logic          iack_q, iack_d;
  logic          dack_q, dack_d;
  logic          err_q, err_d;
  logic [DW-1:0] idata_q, idata_d;
  logic [DW-1:0] drd_q, drd_d;

  logic          i_elig;
  logic          d_elig;
  logic          tmo_hit;

  // A port whose ack is high this cycle has just completed. It is not
  // eligible again until the following cycle.
  assign i_elig = bus.iReq & ~iack_q;
  assign d_elig = bus.dReq & ~dack_q;

`ifdef MEMARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmo_q, tmo_d;

  // The abort fires on the edge that would take the count to TIMEOUT.
  assign tmo_hit = (state_q != IDLE) && !bus.memAck &&
                   (tmo_q == TW'(TIMEOUT - 1));

  always_comb begin
    tmo_d = tmo_q;
    if (state_q == IDLE) begin
      // Every grant is entered from IDLE, so clearing here clears on entry.
      tmo_d = '0;
    end else if (!bus.memAck) begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign tmo_hit        = 1'b0;
`endif

  // Next-state, streak, operand latch and completion logic.
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wr_d     = wr_q;
    iack_d   = 1'b0;
    dack_d   = 1'b0;
    err_d    = 1'b0;
    idata_d  = idata_q;
    drd_d    = drd_q;

    case (state_q)
      IDLE: begin
        // The data port wins unless the fetch has already lost three
        // times in a row while it was waiting.
        if (d_elig && !(i_elig && (streak_q == 2'd3))) begin
          state_d = DGRANT;
          addr_d  = bus.dAddr;
          wr_d    = bus.dWr;
          wdata_d = bus.dWtData;
          if (i_elig && (streak_q != 2'd3)) begin
            streak_d = streak_q + 2'd1;
          end
        end else if (i_elig) begin
          state_d  = IGRANT;
          addr_d   = bus.iAddr;
          streak_d = 2'd0;
        end
        if (!bus.iReq) begin
          streak_d = 2'd0;
        end
      end

      IGRANT: begin
        if (bus.memAck) begin
          idata_d = bus.memRdData;
          iack_d  = 1'b1;
          state_d = IDLE;
        end else if (tmo_hit) begin
          idata_d = '0;
          iack_d  = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end

      DGRANT: begin
        if (bus.memAck) begin
          // A write leaves the last read data in place.
          if (!wr_q) begin
            drd_d = bus.memRdData;
          end
          dack_d  = 1'b1;
          state_d = IDLE;
        end else if (tmo_hit) begin
          drd_d   = '0;
          dack_d  = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      streak_q <= 2'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      iack_q   <= 1'b0;
      dack_q   <= 1'b0;
      err_q    <= 1'b0;
      idata_q  <= '0;
      drd_q    <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
      iack_q   <= iack_d;
      dack_q   <= dack_d;
      err_q    <= err_d;
      idata_q  <= idata_d;
      drd_q    <= drd_d;
    end
  end

  assign bus.memCe     = (state_q != IDLE);
  assign bus.memWe     = (state_q == DGRANT) && wr_q;
  assign bus.memAddr   = addr_q;
  assign bus.memWtData = wdata_q;
  assign bus.iData     = idata_q;
  assign bus.iAck      = iack_q;
  assign bus.dRdData   = drd_q;
  assign bus.dAck      = dack_q;
  assign bus.err       = err_q;
  assign bus.dbg_state = state_q;

  // Stall is combinational so the pipeline holds in the same cycle that it
  // raises a request.
  assign bus.stall = (bus.iReq & ~iack_q) | (bus.dReq & ~dack_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. It contains a behavioural memory,
// requester driver tasks, and a scoreboard: expected read data is queued
// when a request is issued, and a monitor pops and compares it on every ack.
// Directed sections cover reset values, a single fetch, a single write,
// no-ack holding or timeout, and reset in the middle of a grant.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef MEMARB_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 16;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] i_exp_q[$];
  logic [DW-1:0] d_exp_q[$];

  // Reference view of data memory contents, plus the dRdData the data port
  // should currently hold.
  logic [DW-1:0] ref_d [logic [AW-1:0]];
  logic [DW-1:0] last_rd = '0;

  // Behavioural memory contents and its knobs.
  logic [DW-1:0] mem_a [logic [AW-1:0]];
  int            lat_max  = 0;
  bit            hold_ack = 1'b0;
  bit            noise_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mem_init(input logic [AW-1:0] a);
    if (a == 32'h100) return 32'h2402000A;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // ---------------- memory model ----------------
  initial begin
    int wait_cnt;
    int lat;
    wait_cnt = 0;
    lat      = 0;
    bus.memAck    = 1'b0;
    bus.memRdData = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.memCe && !hold_ack && !rst) begin
        if (wait_cnt >= lat) begin
          bus.memAck = 1'b1;
          if (bus.memWe) begin
            // Writes must only ever target the data region.
            check("we_region", (bus.memAddr < 32'h100), 1);
            mem_a[bus.memAddr] = bus.memWtData;
            bus.memRdData = $urandom;
          end else begin
            bus.memRdData = mem_a.exists(bus.memAddr) ? mem_a[bus.memAddr]
                                                      : mem_init(bus.memAddr);
          end
          wait_cnt = 0;
          lat      = $urandom_range(0, lat_max);
        end else begin
          bus.memAck    = 1'b0;
          bus.memRdData = $urandom;
          wait_cnt++;
        end
      end else begin
        // Spurious acks while idle must be ignored by the arbiter.
        bus.memAck    = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.memRdData = $urandom;
        wait_cnt      = 0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic pi;
    logic pd;
    int   d_run;
    pi    = 1'b0;
    pd    = 1'b0;
    d_run = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pi    = 1'b0;
        pd    = 1'b0;
        d_run = 0;
        continue;
      end
      check("stall", bus.stall,
            (bus.iReq & ~bus.iAck) | (bus.dReq & ~bus.dAck));
`ifndef MEMARB_TIMEOUT_EN
      check("err_low", bus.err, 0);
`endif
      if (bus.iAck) begin
        check("iack_pulse", pi, 0);
        if (i_exp_q.size() == 0) begin
          check("iack_unexpected", 1, 0);
        end else begin
          check("iData", bus.iData, i_exp_q.pop_front());
        end
        d_run = 0;
      end
      if (bus.dAck) begin
        check("dack_pulse", pd, 0);
        if (d_exp_q.size() == 0) begin
          check("dack_unexpected", 1, 0);
        end else begin
          check("dRdData", bus.dRdData, d_exp_q.pop_front());
        end
        if (bus.iReq && !bus.iAck) begin
          d_run++;
          check("fetch_starved", (d_run <= 4), 1);
        end
      end
      if (!bus.iReq) d_run = 0;
      pi = bus.iAck;
      pd = bus.dAck;
    end
  end

  // ---------------- driver tasks ----------------
  // Both tasks start and end aligned one time step after a rising edge.
  task automatic drive_i(input int n, input int gap_max);
    for (int k = 0; k < n; k++) begin
      int            g;
      int            c;
      logic [AW-1:0] a;
      g = $urandom_range(0, gap_max);
      if (g > 0) begin
        bus.iReq = 1'b0;
        repeat (g) @(posedge clk);
        #1;
      end
      a = 32'h100 + 4 * $urandom_range(0, 63);
      bus.iReq  = 1'b1;
      bus.iAddr = a;
      i_exp_q.push_back(mem_init(a));
      c = 0;
      do begin
        @(posedge clk);
        #1;
        c++;
      end while (!bus.iAck && c < 200);
      if (!bus.iAck) check("iack_timeout", 0, 1);
    end
    bus.iReq = 1'b0;
  endtask

  task automatic drive_d(input int n, input int gap_max);
    for (int k = 0; k < n; k++) begin
      int            g;
      int            c;
      logic [AW-1:0] a;
      logic [DW-1:0] v;
      logic          wr;
      g = $urandom_range(0, gap_max);
      if (g > 0) begin
        bus.dReq = 1'b0;
        repeat (g) @(posedge clk);
        #1;
      end
      a  = 32'h40 + 4 * $urandom_range(0, 15);
      wr = 1'($urandom_range(0, 1));
      bus.dReq  = 1'b1;
      bus.dWr   = wr;
      bus.dAddr = a;
      if (wr) begin
        v = $urandom;
        bus.dWtData = v;
        d_exp_q.push_back(last_rd);
        ref_d[a] = v;
      end else begin
        bus.dWtData = $urandom;
        v = ref_d.exists(a) ? ref_d[a] : mem_init(a);
        d_exp_q.push_back(v);
        last_rd = v;
      end
      c = 0;
      do begin
        @(posedge clk);
        #1;
        c++;
      end while (!bus.dAck && c < 200);
      if (!bus.dAck) check("dack_timeout", 0, 1);
    end
    bus.dReq = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_memCe"},     bus.memCe,     0);
    check({tag, "_memWe"},     bus.memWe,     0);
    check({tag, "_iAck"},      bus.iAck,      0);
    check({tag, "_dAck"},      bus.dAck,      0);
    check({tag, "_err"},       bus.err,       0);
    check({tag, "_memAddr"},   bus.memAddr,   0);
    check({tag, "_memWtData"}, bus.memWtData, 0);
    check({tag, "_iData"},     bus.iData,     0);
    check({tag, "_dRdData"},   bus.dRdData,   0);
  endtask

  // Holds a data read with memAck suppressed for n grant cycles, then resets.
  task automatic reset_mid_grant(input int n);
    hold_ack  = 1'b1;
    bus.dReq  = 1'b1;
    bus.dWr   = 1'b0;
    bus.dAddr = 32'h4C;
    @(posedge clk);
    #1;
    repeat (n) begin
      @(negedge clk);
      check("hold_memCe", bus.memCe, 1);
      check("hold_no_dAck", bus.dAck, 0);
      @(posedge clk);
      #1;
    end
    rst      = 1'b1;
    bus.dReq = 1'b0;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    hold_ack = 1'b0;
    last_rd  = '0;
    @(negedge clk);
    check_all_zero("midrst");
    @(posedge clk);
    #1;
    @(negedge clk);
    check("midrst_no_dAck", bus.dAck, 0);
    check("midrst_idle", bus.memCe, 0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst         = 1'b1;
    bus.iReq    = 1'b0;
    bus.iAddr   = '0;
    bus.dReq    = 1'b0;
    bus.dWr     = 1'b0;
    bus.dAddr   = '0;
    bus.dWtData = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    check("reset_stall", bus.stall, 0);
    @(posedge clk);
    #1;

    // Single fetch with memAck in the first grant cycle.
    bus.iReq  = 1'b1;
    bus.iAddr = 32'h100;
    i_exp_q.push_back(32'h2402000A);
    @(negedge clk);
    check("fetch_pre_memCe", bus.memCe, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("fetch_memCe", bus.memCe, 1);
    check("fetch_memWe", bus.memWe, 0);
    check("fetch_memAddr", bus.memAddr, 32'h100);
    check("fetch_iAck_early", bus.iAck, 0);
    @(posedge clk);
    #1;
    bus.iReq = 1'b0;
    @(negedge clk);
    check("fetch_iAck", bus.iAck, 1);
    check("fetch_iData", bus.iData, 32'h2402000A);
    check("fetch_memCe_idle", bus.memCe, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("fetch_iAck_drop", bus.iAck, 0);
    check("fetch_iData_hold", bus.iData, 32'h2402000A);
    @(posedge clk);
    #1;

    // Single write.
    bus.dReq    = 1'b1;
    bus.dWr     = 1'b1;
    bus.dAddr   = 32'h40;
    bus.dWtData = 32'h12345678;
    d_exp_q.push_back(last_rd);
    ref_d[32'h40] = 32'h12345678;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("wr_memCe", bus.memCe, 1);
    check("wr_memWe", bus.memWe, 1);
    check("wr_memAddr", bus.memAddr, 32'h40);
    check("wr_memWtData", bus.memWtData, 32'h12345678);
    @(posedge clk);
    #1;
    bus.dReq = 1'b0;
    @(negedge clk);
    check("wr_dAck", bus.dAck, 1);
    check("wr_dRdData", bus.dRdData, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("wr_dAck_drop", bus.dAck, 0);
    check("wr_idle_memAddr", bus.memAddr, 32'h40);
    @(posedge clk);
    #1;

    // Both ports saturated, memory always ready, idle-cycle ack noise.
    noise_en = 1'b1;
    lat_max  = 0;
    fork
      drive_i(40, 0);
      drive_d(40, 0);
    join

    // Random gaps and memory latency.
    lat_max = 3;
    fork
      drive_i(60, 3);
      drive_d(60, 3);
    join
    noise_en = 1'b0;
    lat_max  = 0;
    repeat (4) @(posedge clk);
    #1;
    check("sb_i_empty", i_exp_q.size(), 0);
    check("sb_d_empty", d_exp_q.size(), 0);

`ifdef MEMARB_TIMEOUT_EN
    begin
      int grants;
      int hits;
      int hit_at;
      grants = 0;
      hits   = 0;
      hit_at = -1;
      hold_ack  = 1'b1;
      bus.dReq  = 1'b1;
      bus.dWr   = 1'b0;
      bus.dAddr = 32'h48;
      d_exp_q.push_back('0);
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (bus.dAck && bus.err) begin
          hits++;
          hit_at = grants;
          check("tmo_dRdData", bus.dRdData, 0);
        end
        if (bus.memCe) grants++;
        @(posedge clk);
        #1;
        if (bus.dAck) bus.dReq = 1'b0;
      end
      hold_ack = 1'b0;
      last_rd  = '0;
      check("tmo_once", hits, 1);
      check("tmo_after_grants", hit_at, TMO);
    end
    reset_mid_grant(2);
`else
    reset_mid_grant(100);
`endif

    check("end_i_empty", i_exp_q.size(), 0);
    check("end_d_empty", d_exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
